// File: rtl/home_auto_pkg.sv
// Shared types and default sizes for the home-automation door-lock path.
// The digit constants are also used by the lock checker on the receive side.
package home_auto_pkg;

    localparam int DIGITS_DEF  = 4;
    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SEND
    } tx_state_e;

endpackage

// File: rtl/key_debounce.sv
// Turns the bouncy key_valid level into one accept pulse per press.
// The pulse is combinational so the digit on key_in is captured in the same cycle.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_valid,
    output logic key_accept
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt;

    assign key_accept = key_valid && (cnt == CW'(DEBOUNCE_CYC - 1));

    // Saturating at DEBOUNCE_CYC means a held key never accepts twice
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!key_valid) begin
            cnt <= '0;
        end else if (cnt != CW'(DEBOUNCE_CYC)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_code_tx.sv
// Collects debounced keypad digits into a small buffer and streams the code
// to the lock checker over valid/ready when ENTER is pressed.
module keypad_code_tx
    import home_auto_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEF,
    parameter int DIGIT_W      = DIGIT_W_DEF,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIGIT_W-1:0]           key_in,
    input  logic                         key_valid,
    input  logic                         key_enter,
    input  logic                         key_clear,
    output logic [DIGIT_W-1:0]           code_data,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic                         code_last,
    output logic                         busy,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
    output logic                         timeout_err
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    tx_state_e          state;
    tx_state_e          state_next;
    logic               key_accept;
    logic               timer_hit;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      last_idx;
    logic [TW-1:0]      idle_timer;
    logic [DIGIT_W-1:0] buffer [DIGITS];

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_accept(key_accept)
    );

    assign last_idx   = IW'(entry_cnt - CW'(1));
    assign code_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign code_last  = code_valid && (idx == last_idx);
    assign code_data  = buffer[idx];

    // A fresh accept restarts the idle window, and clear/enter take precedence
    assign timer_hit = (state == COLLECT) && !key_accept && !key_clear && !key_enter
                       && (idle_timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (key_accept) state_next = COLLECT;
            end
            COLLECT: begin
                if (key_clear)      state_next = IDLE;
                else if (key_enter) state_next = SEND;
                else if (timer_hit) state_next = IDLE;
            end
            SEND: begin
                if (code_ready && code_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer, counters and the timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_cnt   <= '0;
            idx         <= '0;
            idle_timer  <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            timeout_err <= timer_hit;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (key_accept) begin
                        buffer[0]  <= key_in;
                        entry_cnt  <= CW'(1);
                        idle_timer <= '0;
                    end
                end
                COLLECT: begin
                    idx <= '0;
                    if (key_clear || timer_hit) begin
                        entry_cnt <= '0;
                    end else if (key_accept) begin
                        idle_timer <= '0;
                        if (entry_cnt < CW'(DIGITS)) begin
                            buffer[entry_cnt[IW-1:0]] <= key_in;
                            entry_cnt                 <= entry_cnt + 1'b1;
                        end
                    end else begin
                        idle_timer <= idle_timer + 1'b1;
                    end
                end
                SEND: begin
                    if (code_ready) begin
                        if (code_last) begin
                            entry_cnt <= '0;
                            idx       <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_code_tx.sv
// Randomised scoreboard bench for keypad_code_tx: a digit-queue model predicts
// the transmitted beats and a separate negedge monitor pops and compares them.
module tb_keypad_code_tx;

    localparam int DIGITS       = 4;
    localparam int DIGIT_W      = 4;
    localparam int DEBOUNCE_CYC = 4;
    localparam int TIMEOUT_CYC  = 100;

    logic               clk = 1'b0;
    logic               rst;
    logic [DIGIT_W-1:0] key_in;
    logic               key_valid;
    logic               key_enter;
    logic               key_clear;
    logic [DIGIT_W-1:0] code_data;
    logic               code_valid;
    logic               code_ready;
    logic               code_last;
    logic               busy;
    logic [2:0]         entry_cnt;
    logic               timeout_err;

    typedef struct {
        logic [DIGIT_W-1:0] data;
        logic               last;
    } beat_t;

    beat_t              exp_q[$];
    logic [DIGIT_W-1:0] model_code[$];
    int                 beat_cyc[$];
    int                 cyc;
    int                 checks;
    int                 errors;
    int                 acc_cyc;
    int                 exp_timeouts;
    int                 seen_timeouts;
    int                 last_to_cyc;
    int                 ready_mode;
    bit                 in_send_model;

    keypad_code_tx #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .code_data  (code_data),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_last  (code_last),
        .busy       (busy),
        .entry_cnt  (entry_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready is driven 2ns after the edge so the negedge monitor never races it
    initial begin
        code_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       code_ready = 1'b1;
                2:       code_ready = 1'b0;
                default: code_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard monitor: beats, hold-stability while stalled, timeout pulses
    initial begin
        bit                 prev_hold = 1'b0;
        logic [DIGIT_W-1:0] prev_data = '0;
        logic               prev_last = 1'b0;
        beat_t              b;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checkOutput("hold_stable", {31'd0, code_valid} << 5 | {27'd0, code_data} << 1 | {31'd0, code_last},
                                {31'd0, 1'b1} << 5 | {27'd0, prev_data} << 1 | {31'd0, prev_last});
                end
                if (code_valid && code_ready) begin
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat", code_data);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat_data", code_data, b.data);
                        checkOutput("beat_last", code_last, b.last);
                    end
                end
                prev_hold = code_valid && !code_ready;
                prev_data = code_data;
                prev_last = code_last;
                if (timeout_err) begin
                    seen_timeouts++;
                    last_to_cyc = cyc;
                end
            end
        end
    end

    task automatic pushCode();
        for (int i = 0; i < model_code.size(); i++) begin
            beat_t b;
            b.data = model_code[i];
            b.last = (i == model_code.size() - 1);
            exp_q.push_back(b);
        end
        model_code.delete();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        checkOutput("send_done", busy, 1'b0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("entry_cnt_after_send", entry_cnt, 0);
    endtask

    // One keypad press; key_in only carries the digit on the accept cycle
    task automatic press(input logic [DIGIT_W-1:0] d, input int h, input int gap,
                         input bit with_enter);
        bit sent = 1'b0;
        for (int i = 0; i < h; i++) begin
            tick();
            key_valid = 1'b1;
            key_enter = 1'b0;
            key_in    = DIGIT_W'($urandom);
            if (i == DEBOUNCE_CYC - 1) begin
                key_in  = d;
                acc_cyc = cyc + 1;
                if (!in_send_model) begin
                    bit was_collecting = (model_code.size() != 0);
                    if (model_code.size() < DIGITS) model_code.push_back(d);
                    if (with_enter) begin
                        key_enter = 1'b1;
                        if (was_collecting) begin
                            pushCode();
                            sent = 1'b1;
                        end
                    end
                end
            end
        end
        tick();
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_in    = DIGIT_W'($urandom);
        for (int i = 0; i < gap; i++) tick();
        if (sent) waitIdle();
        if (!in_send_model) checkOutput("entry_cnt", entry_cnt, model_code.size());
    endtask

    task automatic doEnter(input bit wait_done);
        bit sends = (model_code.size() != 0);
        tick();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        if (sends) pushCode();
        checkOutput("enter_latency_valid", code_valid, sends);
        if (sends && wait_done) waitIdle();
    endtask

    task automatic doClear();
        tick();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        model_code.delete();
        checkOutput("clear_entry_cnt", entry_cnt, 0);
    endtask

    task automatic applyStimulus();
        int op = $urandom_range(0, 8);
        if (op <= 4)      press(DIGIT_W'($urandom), $urandom_range(DEBOUNCE_CYC, 7),
                                $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
        else if (op == 5) press(DIGIT_W'($urandom), $urandom_range(1, DEBOUNCE_CYC - 1),
                                $urandom_range(1, 4), 1'b0);
        else if (op <= 7) doEnter(1'b1);
        else              doClear();
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
        cyc = 0; checks = 0; errors = 0; exp_timeouts = 0; seen_timeouts = 0;
        ready_mode = 1; in_send_model = 1'b0; acc_cyc = 0; last_to_cyc = 0;
        tick(); tick();
        checkOutput("reset_code_valid", code_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_entry_cnt", entry_cnt, 0);
        checkOutput("reset_code_data", code_data, 0);
        checkOutput("reset_timeout_err", timeout_err, 0);
        rst = 1'b0;
        tick();

        $display("[TB] 4-digit code, ready high");
        beat_cyc.delete();
        press(4'd1, 6, 2, 1'b0); press(4'd0, 6, 2, 1'b0);
        press(4'd1, 6, 2, 1'b0); press(4'd1, 6, 2, 1'b0);
        doEnter(1'b1);
        checkOutput("four_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) checkOutput("beats_consecutive", beat_cyc[3] - beat_cyc[0], 3);

        $display("[TB] short presses rejected");
        press(4'd5, 3, 2, 1'b0);
        press(4'd6, 1, 2, 1'b0);

        $display("[TB] stalled handshake");
        ready_mode = 2;
        press(4'd7, 5, 1, 1'b0); press(4'd2, 5, 1, 1'b0);
        doEnter(1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_data", code_data, 7);
            checkOutput("stall_last", code_last, 0);
            tick();
        end
        ready_mode = 1;
        waitIdle();

        $display("[TB] overflow drops fifth digit");
        for (int i = 0; i < 5; i++) press(DIGIT_W'(i + 3), 5, 1, 1'b0);
        doEnter(1'b1);

        $display("[TB] idle timeout");
        ready_mode = 0;
        press(4'd9, 6, 0, 1'b0);
        exp_timeouts++;
        model_code.delete();
        for (int i = 0; i < TIMEOUT_CYC + 10; i++) tick();
        checkOutput("timeout_pulses", seen_timeouts, exp_timeouts);
        checkOutput("timeout_cycle", last_to_cyc, acc_cyc + TIMEOUT_CYC);
        checkOutput("timeout_entry_cnt", entry_cnt, 0);
        doEnter(1'b1);

        $display("[TB] clear and enter together");
        press(4'd3, 5, 1, 1'b0); press(4'd4, 5, 1, 1'b0);
        tick();
        key_clear = 1'b1; key_enter = 1'b1;
        tick();
        key_clear = 1'b0; key_enter = 1'b0;
        model_code.delete();
        checkOutput("clr_enter_valid", code_valid, 0);
        checkOutput("clr_enter_cnt", entry_cnt, 0);
        tick();
        checkOutput("clr_enter_busy", busy, 0);

        $display("[TB] keypad ignored during send");
        ready_mode = 2;
        press(4'd1, 5, 1, 1'b0); press(4'd2, 5, 1, 1'b0); press(4'd3, 5, 1, 1'b0);
        doEnter(1'b0);
        in_send_model = 1'b1;
        press(4'd9, 6, 1, 1'b0);
        in_send_model = 1'b0;
        ready_mode = 1;
        waitIdle();

        $display("[TB] reset during send");
        ready_mode = 2;
        press(4'd5, 5, 1, 1'b0); press(4'd6, 5, 1, 1'b0);
        doEnter(1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_send_valid", code_valid, 0);
        checkOutput("rst_send_busy", busy, 0);
        checkOutput("rst_send_last", code_last, 0);
        checkOutput("rst_send_data", code_data, 0);
        checkOutput("rst_send_cnt", entry_cnt, 0);
        rst = 1'b0;
        exp_q.delete();
        model_code.delete();
        ready_mode = 0;
        tick();

        $display("[TB] random sequence");
        for (int n = 0; n < 60; n++) applyStimulus();
        doEnter(1'b1);

        for (int i = 0; i < 5; i++) tick();
        checkOutput("final_scoreboard_empty", exp_q.size(), 0);
        checkOutput("final_timeout_pulses", seen_timeouts, exp_timeouts);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
